// File: rtl/level_ctrl_if.sv
// Bundles the level controller's game-side inputs and status outputs.
// The master drives the stimulus and the slave is the controller itself.
interface level_ctrl_if;
    logic        frame_tick;
    logic        start;
    logic [31:0] eaten;
    logic        ghost_hit;
    logic        dots_clear;
    logic        freeze;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic [2:0]  state;
    logic [5:0]  dots_left;

    modport master (
        output frame_tick, start, eaten, ghost_hit,
        input  dots_clear, freeze, score, lives, level, state, dots_left
    );

    modport slave (
        input  frame_tick, start, eaten, ghost_hit,
        output dots_clear, freeze, score, lives, level, state, dots_left
    );
endinterface

// File: rtl/level_ctrl.sv
// Pac-Man level sequencer: READY/PLAY/CLEAR/DEATH/OVER flow, lives, level, and
// saturating dot scoring from rising edges of the eaten flags.
module level_ctrl #(
    parameter int READY_FRAMES = 120,
    parameter int CLEAR_FRAMES = 90,
    parameter int DEATH_FRAMES = 60,
    parameter int DOT_POINTS   = 10,
    parameter int START_LIVES  = 3
) (
    input logic         Clk,
    input logic         Reset,
    level_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        CLEAR = 3'd3,
        DEATH = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [7:0] READY_T = 8'(READY_FRAMES);
    localparam logic [7:0] CLEAR_T = 8'(CLEAR_FRAMES);
    localparam logic [7:0] DEATH_T = 8'(DEATH_FRAMES);
    localparam logic [1:0] LIVES_0 = 2'(START_LIVES);

    function automatic logic [5:0] popcnt(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
        return c;
    endfunction

    state_t      st;
    logic [31:0] eaten_q;
    logic [31:0] new_bits;
    logic [5:0]  new_cnt;
    logic [31:0] sum;
    logic [15:0] score_r;
    logic [15:0] score_sat;
    logic [7:0]  timer;
    logic [7:0]  timer_inc;
    logic [1:0]  lives_r;
    logic [3:0]  level_r;
    logic        clr_r;
    logic        clr_d;
    logic        freeze_r;

    assign new_bits  = bus.eaten & ~eaten_q;
    assign new_cnt   = popcnt(new_bits);
    assign sum       = {16'd0, score_r} + 32'(new_cnt) * 32'(DOT_POINTS);
    assign score_sat = (|sum[31:16]) ? 16'hFFFF : sum[15:0];
    assign timer_inc = timer + 8'd1;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            st       <= IDLE;
            score_r  <= '0;
            lives_r  <= '0;
            level_r  <= '0;
            timer    <= '0;
            eaten_q  <= bus.eaten;
            clr_r    <= 1'b1;
            clr_d    <= 1'b0;
            freeze_r <= 1'b1;
        end else begin
            clr_r   <= 1'b0;
            clr_d   <= clr_r;
            eaten_q <= bus.eaten;
            // Dots flipping back during a board clear must not be scored.
            if (!clr_r && !clr_d) score_r <= score_sat;

            case (st)
                IDLE, OVER: begin
                    // Gating on clr_r keeps dots_clear from pulsing back-to-back after reset.
                    if (bus.start && !clr_r) begin
                        st       <= READY;
                        score_r  <= '0;
                        lives_r  <= LIVES_0;
                        level_r  <= 4'd1;
                        timer    <= '0;
                        clr_r    <= 1'b1;
                        freeze_r <= 1'b1;
                    end
                end
                READY: begin
                    if (bus.frame_tick) begin
                        if (timer_inc == READY_T) begin
                            st       <= PLAY;
                            timer    <= '0;
                            freeze_r <= 1'b0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
                PLAY: begin
                    if (&bus.eaten) begin
                        st       <= CLEAR;
                        timer    <= '0;
                        freeze_r <= 1'b1;
                    end else if (bus.ghost_hit) begin
                        st       <= DEATH;
                        timer    <= '0;
                        freeze_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (bus.frame_tick) begin
                        if (timer_inc == CLEAR_T) begin
                            st      <= READY;
                            timer   <= '0;
                            clr_r   <= 1'b1;
                            level_r <= (level_r == 4'd15) ? 4'd15 : level_r + 4'd1;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
                DEATH: begin
                    if (bus.frame_tick) begin
                        if (timer_inc == DEATH_T) begin
                            timer   <= '0;
                            lives_r <= lives_r - 2'd1;
                            st      <= (lives_r == 2'd1) ? OVER : READY;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
                default: begin
                    st       <= IDLE;
                    timer    <= '0;
                    freeze_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.dots_clear = clr_r;
    assign bus.freeze     = freeze_r;
    assign bus.score      = score_r;
    assign bus.lives      = lives_r;
    assign bus.level      = level_r;
    assign bus.state      = st;
    assign bus.dots_left  = 6'd32 - popcnt(bus.eaten);
endmodule

// File: tb/tb_level_ctrl.sv
// Directed checks of the level controller: game flow, scoring, saturation and
// mid-game reset, with hand-computed expectations.
module tb_level_ctrl;
    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    level_ctrl_if bus ();

    level_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        Reset          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.eaten      = '0;
        bus.ghost_hit  = 1'b0;

        // reset state
        step();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_lives", 32'(bus.lives), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_clr", 32'(bus.dots_clear), 1);
        chk("rst_freeze", 32'(bus.freeze), 1);
        chk("rst_left", 32'(bus.dots_left), 32);
        Reset = 1'b1;
        step();
        chk("rst_clr_drop", 32'(bus.dots_clear), 0);

        // start and READY hold
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_state", 32'(bus.state), 1);
        chk("start_clr", 32'(bus.dots_clear), 1);
        chk("start_lives", 32'(bus.lives), 3);
        chk("start_level", 32'(bus.level), 1);
        step();
        chk("start_clr_1w", 32'(bus.dots_clear), 0);
        tick(119);
        chk("ready_119", 32'(bus.state), 1);
        chk("ready_freeze", 32'(bus.freeze), 1);
        tick(1);
        chk("play_state", 32'(bus.state), 2);
        chk("play_freeze", 32'(bus.freeze), 0);
        chk("play_score", 32'(bus.score), 0);
        chk("play_lives", 32'(bus.lives), 3);
        chk("play_level", 32'(bus.level), 1);

        // multiple new dots and a re-raised bit
        bus.eaten = 32'h0000_0021;
        step();
        chk("two_dots", 32'(bus.score), 20);
        chk("left_30", 32'(bus.dots_left), 30);
        bus.eaten = 32'h0000_0020;
        step();
        chk("fall_nochg", 32'(bus.score), 20);
        bus.eaten = 32'h0000_0021;
        step();
        chk("reraise", 32'(bus.score), 30);

        // full board wins over ghost_hit; 30 newly eaten dots score 300
        bus.eaten     = 32'hFFFF_FFFF;
        bus.ghost_hit = 1'b1;
        step();
        bus.ghost_hit = 1'b0;
        chk("clear_prio", 32'(bus.state), 3);
        chk("clear_freeze", 32'(bus.freeze), 1);
        chk("clear_score", 32'(bus.score), 330);
        chk("clear_left", 32'(bus.dots_left), 0);
        tick(89);
        chk("clear_89", 32'(bus.state), 3);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        chk("clear_done", 32'(bus.state), 1);
        chk("clear_pulse", 32'(bus.dots_clear), 1);
        chk("level_2", 32'(bus.level), 2);
        bus.eaten = '0;
        step();
        chk("clear_1w", 32'(bus.dots_clear), 0);
        chk("clear_keep", 32'(bus.score), 330);
        chk("left_32", 32'(bus.dots_left), 32);
        tick(120);
        chk("play2", 32'(bus.state), 2);

        // three deaths to game over
        for (int k = 0; k < 3; k++) begin
            bus.ghost_hit = 1'b1;
            step();
            bus.ghost_hit = 1'b0;
            chk("death", 32'(bus.state), 4);
            tick(60);
            if (k < 2) begin
                chk("death_ready", 32'(bus.state), 1);
                chk("death_lives", 32'(bus.lives), 32'(2 - k));
                chk("death_noclr", 32'(bus.dots_clear), 0);
                bus.ghost_hit = 1'b1;
                step();
                bus.ghost_hit = 1'b0;
                chk("ghost_ign", 32'(bus.state), 1);
                tick(120);
                chk("replay", 32'(bus.state), 2);
            end else begin
                chk("over", 32'(bus.state), 5);
                chk("over_lives", 32'(bus.lives), 0);
                chk("over_freeze", 32'(bus.freeze), 1);
                chk("over_score", 32'(bus.score), 330);
            end
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart", 32'(bus.state), 1);
        chk("restart_score", 32'(bus.score), 0);
        chk("restart_lives", 32'(bus.lives), 3);
        chk("restart_level", 32'(bus.level), 1);

        // reset in DEATH with timer=30
        tick(120);
        bus.ghost_hit = 1'b1;
        step();
        bus.ghost_hit = 1'b0;
        chk("death_b", 32'(bus.state), 4);
        tick(30);
        Reset     = 1'b0;
        bus.eaten = 32'h0000_0003;
        step();
        chk("mid_rst_state", 32'(bus.state), 0);
        chk("mid_rst_lives", 32'(bus.lives), 0);
        chk("mid_rst_clr", 32'(bus.dots_clear), 1);
        chk("mid_rst_score", 32'(bus.score), 0);
        Reset     = 1'b1;
        bus.eaten = 32'h0000_0007;
        step();
        chk("post_rst_score", 32'(bus.score), 0);
        chk("post_rst_clr", 32'(bus.dots_clear), 0);

        // saturation: 204 full boards = 0xFF00, +24 dots = 0xFFF0
        bus.eaten = '0;
        step();
        step();
        for (int i = 0; i < 204; i++) begin
            bus.eaten = 32'hFFFF_FFFF;
            step();
            bus.eaten = '0;
            step();
        end
        chk("sat_ff00", 32'(bus.score), 32'hFF00);
        bus.eaten = 32'h00FF_FFFF;
        step();
        chk("sat_fff0", 32'(bus.score), 32'hFFF0);
        bus.eaten = '0;
        step();
        bus.eaten = 32'h0000_000F;
        step();
        chk("sat_ffff", 32'(bus.score), 32'hFFFF);
        chk("left_28", 32'(bus.dots_left), 28);
        bus.eaten = '0;
        step();
        bus.eaten = 32'h0000_000F;
        step();
        chk("sat_hold", 32'(bus.score), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
